// File: rtl/pwl_reg_readback.sv
// rtl/pwl_reg_readback.sv - burst readback of per-channel synth registers as a byte stream
// Each 16-bit register is fetched, masked to its field width and sent low byte first.
module pwl_reg_readback #(
  parameter int NUM_CH     = 4,
  parameter int BURST_BITS = 5,
  localparam int CH_BITS   = $clog2(NUM_CH),
  localparam int ADDR_W    = CH_BITS + 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [BURST_BITS-1:0] req_len,
  output logic                  reg_re,
  output logic [ADDR_W-1:0]     reg_raddr,
  input  logic [15:0]           reg_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND_LO,
    SEND_HI
  } state_t;

  state_t                state, state_n;
  logic [ADDR_W-1:0]     cur_addr, cur_addr_n;
  logic [BURST_BITS-1:0] remaining, remaining_n;
  logic [15:0]           data, data_n;

  logic                  req_ready_n;
  logic                  reg_re_n;
  logic [ADDR_W-1:0]     reg_raddr_n;
  logic                  out_valid_n;
  logic [7:0]            out_data_n;
  logic                  busy_n;

  // Field widths of the eight per-channel registers; unused bits read as 0.
  function automatic logic [15:0] field_mask(input logic [2:0] reg_idx);
    case (reg_idx)
      3'd0:                field_mask = 16'h1FFF;
      3'd1:                field_mask = 16'h003F;
      3'd2, 3'd3, 3'd4:    field_mask = 16'h00FF;
      default:             field_mask = 16'hFFFF;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    remaining_n = remaining;
    data_n      = data;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          cur_addr_n  = req_addr;
          remaining_n = req_len;
          state_n     = FETCH;
        end
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        data_n  = reg_rdata & field_mask(cur_addr[2:0]);
        state_n = SEND_LO;
      end
      SEND_LO: begin
        if (out_ready) state_n = SEND_HI;
      end
      SEND_HI: begin
        if (out_ready) begin
          if (remaining == '0) begin
            state_n = IDLE;
          end else begin
            remaining_n = remaining - 1'b1;
            cur_addr_n  = cur_addr + 1'b1;
            state_n     = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the block registered.
    req_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
    reg_re_n    = (state_n == FETCH);
    reg_raddr_n = (state_n == FETCH) ? cur_addr_n : reg_raddr;
    out_valid_n = (state_n == SEND_LO) || (state_n == SEND_HI);
    out_data_n  = 8'h00;
    if (state_n == SEND_LO) out_data_n = data_n[7:0];
    if (state_n == SEND_HI) out_data_n = data_n[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      data      <= '0;
      req_ready <= 1'b1;
      reg_re    <= 1'b0;
      reg_raddr <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      remaining <= remaining_n;
      data      <= data_n;
      req_ready <= req_ready_n;
      reg_re    <= reg_re_n;
      reg_raddr <= reg_raddr_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      busy      <= busy_n;
    end
  end

  a_re_only_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    reg_re |-> (state == FETCH));
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state != IDLE));

endmodule

// File: tb/tb_pwl_reg_readback.sv
// tb/tb_pwl_reg_readback.sv - directed self-checking bench for pwl_reg_readback
module tb_pwl_reg_readback;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_addr = '0;
  logic [4:0] req_len = '0;
  logic       reg_re;
  logic [4:0] reg_raddr;
  logic [15:0] reg_rdata = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] regs [0:31];
  logic [7:0]  byte_q[$];
  logic [4:0]  raddr_q[$];
  logic [4:0]  acc_q[$];

  pwl_reg_readback #(.NUM_CH(4), .BURST_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .reg_re(reg_re), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file with one-cycle synchronous read latency.
  always @(posedge clk) if (reg_re) reg_rdata <= regs[reg_raddr];

  always @(posedge clk) begin
    if (out_valid && out_ready) byte_q.push_back(out_data);
    if (reg_re) raddr_q.push_back(reg_raddr);
    if (req_valid && req_ready) acc_q.push_back(req_addr);
  end

  task automatic clear_logs();
    byte_q.delete();
    raddr_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (reg_re !== 1'b0) begin errors++; $display("FAIL reset_reg_re got=%b exp=0", reg_re); end
    checks++; if (reg_raddr !== 5'd0) begin errors++; $display("FAIL reset_raddr got=%0d exp=0", reg_raddr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    regs[13] = 16'hBEEF;
    clear_logs();
    out_ready = 1'b1;
    req_addr = 5'd13; req_len = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (reg_re !== 1'b1 || reg_raddr !== 5'd13) begin errors++; $display("FAIL single_fetch got re=%b raddr=%0d exp re=1 raddr=13", reg_re, reg_raddr); end
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL single_busy got busy=%b rdy=%b exp 1 0", busy, req_ready); end
    @(posedge clk); #1;
    checks++; if (reg_re !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_latch got re=%b ov=%b exp 0 0", reg_re, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hEF) begin errors++; $display("FAIL single_lo got ov=%b data=%h exp 1 ef", out_valid, out_data); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hBE) begin errors++; $display("FAIL single_hi got ov=%b data=%h exp 1 be", out_valid, out_data); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL single_done got busy=%b ov=%b rdy=%b exp 0 0 1", busy, out_valid, req_ready); end
    checks++; if (byte_q.size() != 2 || raddr_q.size() != 1) begin errors++; $display("FAIL single_counts got bytes=%0d reads=%0d exp 2 1", byte_q.size(), raddr_q.size()); end
    else begin
      checks++; if (byte_q[0] !== 8'hEF || byte_q[1] !== 8'hBE) begin errors++; $display("FAIL single_bytes got %h %h exp ef be", byte_q[0], byte_q[1]); end
    end
  endtask

  task automatic test_masking();
    logic [7:0] exp_b [0:5];
    bit ok;
    exp_b[0] = 8'hFF; exp_b[1] = 8'h1F; exp_b[2] = 8'h3F;
    exp_b[3] = 8'h00; exp_b[4] = 8'h34; exp_b[5] = 8'h00;
    regs[8] = 16'hFFFF; regs[9] = 16'hFFFF; regs[10] = 16'h1234;
    clear_logs();
    out_ready = 1'b1;
    req_addr = 5'd8; req_len = 5'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_timeout got busy=%b exp 0", busy); end
    checks++; if (byte_q.size() != 6) begin errors++; $display("FAIL mask_count got %0d exp 6", byte_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (byte_q[i] !== exp_b[i]) begin errors++; $display("FAIL mask_byte%0d got %h exp %h", i, byte_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    regs[13] = 16'hBEEF;
    clear_logs();
    out_ready = 1'b0;
    req_addr = 5'd13; req_len = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hEF || reg_re !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got ov=%b data=%h re=%b exp 1 ef 0", i, out_valid, out_data, reg_re); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got busy=%b exp 0", busy); end
    checks++; if (byte_q.size() != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", byte_q.size()); end
    else begin
      checks++; if (byte_q[0] !== 8'hEF || byte_q[1] !== 8'hBE) begin errors++; $display("FAIL bp_bytes got %h %h exp ef be", byte_q[0], byte_q[1]); end
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp_b [0:5];
    logic [4:0] exp_a [0:2];
    bit ok, rdy_bad;
    exp_b[0] = 8'h5A; exp_b[1] = 8'hA5; exp_b[2] = 8'hD2;
    exp_b[3] = 8'hC3; exp_b[4] = 8'hFF; exp_b[5] = 8'h1F;
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0;
    regs[30] = 16'hA55A; regs[31] = 16'hC3D2; regs[0] = 16'hFFFF;
    clear_logs();
    out_ready = 1'b1;
    req_addr = 5'd30; req_len = 5'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ok = 1'b0; rdy_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      if (req_ready !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got busy=%b exp 0", busy); end
    checks++; if (rdy_bad) begin errors++; $display("FAIL wrap_req_ready got high while busy exp low"); end
    checks++; if (raddr_q.size() != 3) begin errors++; $display("FAIL wrap_reads got %0d exp 3", raddr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (raddr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_raddr%0d got %0d exp %0d", i, raddr_q[i], exp_a[i]); end
    end
    checks++; if (byte_q.size() != 6) begin errors++; $display("FAIL wrap_count got %0d exp 6", byte_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (byte_q[i] !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d got %h exp %h", i, byte_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_req_during_busy();
    bit ok;
    regs[5] = 16'h0042; regs[20] = 16'h7777;
    clear_logs();
    out_ready = 1'b1;
    req_addr = 5'd5; req_len = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 5'd20;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0 || acc_q.size() != 1) begin errors++; $display("FAIL busy_req_blocked got rdy=%b accepts=%0d exp 0 1", req_ready, acc_q.size()); end
    wait_idle(ok);
    checks++; if (!ok || req_ready !== 1'b1) begin errors++; $display("FAIL busy_idle_gap got ok=%b rdy=%b exp 1 1", ok, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_second_timeout got busy=%b exp 0", busy); end
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL busy_accepts got %0d exp 2", acc_q.size()); end
    else begin
      checks++; if (acc_q[1] !== 5'd20) begin errors++; $display("FAIL busy_accept_addr got %0d exp 20", acc_q[1]); end
    end
    checks++; if (byte_q.size() != 4) begin errors++; $display("FAIL busy_count got %0d exp 4", byte_q.size()); end
    else begin
      checks++; if (byte_q[0] !== 8'h42 || byte_q[1] !== 8'h00 || byte_q[2] !== 8'h77 || byte_q[3] !== 8'h00)
        begin errors++; $display("FAIL busy_bytes got %h %h %h %h exp 42 00 77 00", byte_q[0], byte_q[1], byte_q[2], byte_q[3]); end
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    regs[13] = 16'hBEEF;
    clear_logs();
    out_ready = 1'b0;
    req_addr = 5'd13; req_len = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hBE) begin errors++; $display("FAIL rst_pre_hi got ov=%b data=%h exp 1 be", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || out_data !== 8'h00)
      begin errors++; $display("FAIL rst_async got ov=%b busy=%b rdy=%b data=%h exp 0 0 1 00", out_valid, busy, req_ready, out_data); end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (byte_q.size() != 1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_partial got bytes=%0d ov=%b exp 1 0", byte_q.size(), out_valid); end
    clear_logs();
    req_addr = 5'd13; req_len = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_fresh_timeout got busy=%b exp 0", busy); end
    checks++; if (byte_q.size() != 2) begin errors++; $display("FAIL rst_fresh_count got %0d exp 2", byte_q.size()); end
    else begin
      checks++; if (byte_q[0] !== 8'hEF || byte_q[1] !== 8'hBE) begin errors++; $display("FAIL rst_fresh_bytes got %h %h exp ef be", byte_q[0], byte_q[1]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 16'h0000;
    test_reset();
    test_single();
    test_masking();
    test_backpressure();
    test_burst_wrap();
    test_req_during_busy();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
